deserializer: RTL
=================

// Module: deserializer
// PURPOSE
//   Receive-side counterpart of the 4:1 word serializer. Collects a stream of
//   WIDTH-bit words, framed by a start-of-frame flag on word 0, into four
//   parallel words O0..O3. Presents each complete frame to the downstream
//   consumer with a valid/ready handshake. Sits at the far end of the serial
//   link and feeds parallel datapath logic.
// PARAMETERS
//   WIDTH   16   bit width of each serial word and of each parallel output
// PORTS
//   CLK        in   1      clock; all state changes on posedge
//   RESETN     in   1      asynchronous active-low reset
//   I          in   WIDTH  serial input word
//   I_VALID    in   1      I carries a word this cycle
//   I_SOF      in   1      qualifies I as word 0 of a frame (ignored if !I_VALID)
//   I_READY    out  1      block accepts I this cycle; accept = I_VALID & I_READY
//   O0..O3     out  WIDTH  parallel frame; O0 = first (SOF) word, O3 = last
//   O_VALID    out  1      O0..O3 hold an unconsumed frame
//   O_READY    in   1      consumer takes the frame; take = O_VALID & O_READY
//   FRAME_ERR  out  1      one-cycle pulse on a framing error
// BEHAVIOUR
//   Reset (RESETN=0, async): state=HUNT, cnt=0, s0..s2=0, O0..O3=0, O_VALID=0,
//     FRAME_ERR=0. Takes effect immediately. A partial frame is lost and a
//     held output frame is dropped.
//   States: HUNT (wait for SOF), COLLECT (cnt = index of next word, 1..3).
//   Every transition below happens only on an accept cycle; otherwise state
//     is held.
//   HUNT, accept, I_SOF=1: s0<=I, cnt<=1, go to COLLECT.
//   HUNT, accept, I_SOF=0: word dropped, FRAME_ERR pulses next cycle.
//   COLLECT, accept, I_SOF=0, cnt in 1..2: s[cnt]<=I, cnt<=cnt+1.
//   COLLECT, accept, I_SOF=0, cnt=3: O0<=s0, O1<=s1, O2<=s2, O3<=I,
//     O_VALID<=1, cnt<=0, go to HUNT.
//   COLLECT, accept, I_SOF=1 (early SOF at any cnt): partial frame discarded,
//     FRAME_ERR pulses, s0<=I, cnt<=1, stay in COLLECT. SOF has priority over
//     completion.
//   I_READY (combinational) = !(state==COLLECT && cnt==3 && O_VALID && !O_READY).
//     Input stalls only when the last word would overwrite an unconsumed
//     frame. Words 0..2 are always accepted.
//   O_VALID: set on completion; cleared on take. If take and completion fall
//     in the same cycle, O_VALID stays 1 and O0..O3 load the new frame
//     (back-to-back, no bubble).
//   O0..O3 are stable while O_VALID=1 and take has not occurred.
//   Latency: O_VALID rises in the cycle after the 4th word is accepted.
//     Sustained throughput is 1 frame per 4 cycles with O_READY held at 1.
//   FRAME_ERR: registered, asserted exactly the cycle after the offending
//     accept, never asserted for 2+ cycles per error. Consecutive errors give
//     consecutive pulses.
//   I_VALID=0 bubbles anywhere in a frame are allowed; cnt does not advance.
// TESTING
//   1. Reset; I_VALID=1 each cycle, words A0(SOF),A1,A2,A3 = 16'h1111..16'h4444,
//      O_READY=1 -> cycle after A3: O_VALID=1, O0..O3=1111,2222,3333,4444,
//      FRAME_ERR never asserted.
//   2. Two back-to-back frames, O_READY=1 -> O_VALID stays high for 1 cycle
//      per frame, 4 cycles apart; I_READY constant 1.
//   3. Frame 1 done, O_READY=0, frame 2 sent -> I_READY=0 at frame-2 word 3.
//      O0..O3 hold frame 1. Raise O_READY -> word 3 accepted that cycle and
//      O0..O3 = frame 2 next cycle.
//   4. Send 16'hDEAD without SOF from reset -> dropped, FRAME_ERR one-cycle
//      pulse, O_VALID stays 0. A following valid frame is received intact.
//   5. SOF, B1, then SOF with 16'hC000, C1, C2, C3 -> FRAME_ERR pulses once;
//      output frame = C000,C1,C2,C3.
//   6. Assert RESETN=0 mid-frame after 2 words and while O_VALID=1 -> all
//      outputs 0 immediately. The next full SOF frame decodes correctly.

Source files
------------

// File: rtl/deserializer.sv
// Purpose : 1:4 word deserializer. Gathers a SOF-framed serial word stream into one parallel frame O0..O3.
// Latency : O_VALID rises in the cycle after the 4th word of a frame is accepted.
// Backpres: I_READY drops only when the last word would overwrite a frame that is still held; words 0..2 are always accepted.
//
// Ports:
//   CLK, RESETN        clock (posedge) and asynchronous active-low reset
//   I, I_VALID, I_SOF  serial word, its qualifier, start-of-frame flag (word 0)
//   I_READY            the block accepts I this cycle (accept = I_VALID & I_READY)
//   O0..O3             parallel frame, O0 = SOF word, O3 = last word
//   O_VALID, O_READY   output handshake (take = O_VALID & O_READY)
//   FRAME_ERR          one-cycle pulse after a word that breaks framing
module deserializer #(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RESETN,
    input  logic [WIDTH-1:0] I,
    input  logic             I_VALID,
    input  logic             I_SOF,
    output logic             I_READY,
    output logic [WIDTH-1:0] O0,
    output logic [WIDTH-1:0] O1,
    output logic [WIDTH-1:0] O2,
    output logic [WIDTH-1:0] O3,
    output logic             O_VALID,
    input  logic             O_READY,
    output logic             FRAME_ERR
);

    typedef enum logic {
        HUNT    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    state_t           state_q;
    logic [1:0]       cnt_q;      // index of the next word while collecting
    logic [WIDTH-1:0] s0_q;
    logic [WIDTH-1:0] s1_q;
    logic [WIDTH-1:0] s2_q;
    logic [WIDTH-1:0] o0_q;
    logic [WIDTH-1:0] o1_q;
    logic [WIDTH-1:0] o2_q;
    logic [WIDTH-1:0] o3_q;
    logic             ovld_q;
    logic             ferr_q;

    logic at_last;
    logic accept;
    logic take;

    // The only stall: the closing word would land on a frame nobody has taken.
    // A take in the same cycle frees the output, so the word may go through.
    assign at_last = (state_q == COLLECT) && (cnt_q == 2'd3);
    assign I_READY = !(at_last && ovld_q && !O_READY);
    assign accept  = I_VALID && I_READY;
    assign take    = ovld_q && O_READY;

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q <= HUNT;
            cnt_q   <= 2'd0;
            s0_q    <= '0;
            s1_q    <= '0;
            s2_q    <= '0;
            o0_q    <= '0;
            o1_q    <= '0;
            o2_q    <= '0;
            o3_q    <= '0;
            ovld_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            ferr_q <= 1'b0;

            // Completion below may re-set this in the same cycle (no bubble).
            if (take) begin
                ovld_q <= 1'b0;
            end

            if (accept) begin
                if (I_SOF) begin
                    // SOF always restarts a frame; arriving mid-frame it also
                    // discards the partial frame and flags it, even at cnt==3.
                    if (state_q == COLLECT) begin
                        ferr_q <= 1'b1;
                    end
                    s0_q    <= I;
                    cnt_q   <= 2'd1;
                    state_q <= COLLECT;
                end else if (state_q == HUNT) begin
                    // Word with no frame to belong to: dropped.
                    ferr_q <= 1'b1;
                end else if (cnt_q == 2'd3) begin
                    o0_q    <= s0_q;
                    o1_q    <= s1_q;
                    o2_q    <= s2_q;
                    o3_q    <= I;
                    ovld_q  <= 1'b1;
                    cnt_q   <= 2'd0;
                    state_q <= HUNT;
                end else begin
                    if (cnt_q == 2'd1) begin
                        s1_q <= I;
                    end else begin
                        s2_q <= I;
                    end
                    cnt_q <= cnt_q + 2'd1;
                end
            end
        end
    end

    assign O0        = o0_q;
    assign O1        = o1_q;
    assign O2        = o2_q;
    assign O3        = o3_q;
    assign O_VALID   = ovld_q;
    assign FRAME_ERR = ferr_q;

endmodule
